// File: rtl/motor_plant.sv
`default_nettype none
// ============================================================================
// Module   : motor_plant
// Brief    : Behavioural door/motor actuator. Turns motor_up/motor_dn into a
//            moving position with spin-up delay, finite step rate and end-stop
//            overrun detection; raises sticky faults on illegal drive.
// Revision : 1.0 - initial release
// ============================================================================
module motor_plant #(
  parameter int POS_W       = 8,
  parameter int TRAVEL      = 16,
  parameter int INIT_POS    = 0,
  parameter int START_DLY   = 2,
  parameter int STEP_DIV    = 4,
  parameter int OVERRUN_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             motor_up,
  input  logic             motor_dn,
  input  logic             fault_clr,
  output logic [POS_W-1:0] position,
  output logic             up_limit,
  output logic             dn_limit,
  output logic             moving,
  output logic             fault,
  output logic [1:0]       fault_code
);

  // Counter widths hold 0..N-1; at least one bit even when N is 1.
  localparam int SPIN_W = (START_DLY   > 1) ? $clog2(START_DLY)   : 1;
  localparam int STEP_W = (STEP_DIV    > 1) ? $clog2(STEP_DIV)    : 1;
  localparam int OVR_W  = (OVERRUN_MAX > 1) ? $clog2(OVERRUN_MAX) : 1;

  localparam logic [POS_W-1:0]  c_travel    = POS_W'(TRAVEL);
  localparam logic [POS_W-1:0]  c_init_pos  = POS_W'(INIT_POS);
  localparam logic [POS_W-1:0]  c_pos_zero  = '0;
  localparam logic [SPIN_W-1:0] c_spin_last = SPIN_W'(START_DLY - 1);
  localparam logic [STEP_W-1:0] c_step_last = STEP_W'(STEP_DIV - 1);
  localparam logic [OVR_W-1:0]  c_ovr_last  = OVR_W'(OVERRUN_MAX - 1);

  localparam logic [1:0] c_code_none    = 2'd0;
  localparam logic [1:0] c_code_both    = 2'd1;
  localparam logic [1:0] c_code_overrun = 2'd2;
  localparam logic [1:0] c_code_reverse = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SPIN_UP = 3'd1,
    ST_SPIN_DN = 3'd2,
    ST_MOVE_UP = 3'd3,
    ST_MOVE_DN = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  state_t              r_state,      w_state;
  logic [POS_W-1:0]    r_position,   w_position;
  logic [SPIN_W-1:0]   r_spin_cnt,   w_spin_cnt;
  logic [STEP_W-1:0]   r_step_cnt,   w_step_cnt;
  logic [OVR_W-1:0]    r_ovr_cnt,    w_ovr_cnt;
  logic [1:0]          r_fault_code, w_fault_code;
  logic                w_both;

  assign w_both = motor_up & motor_dn;

  // State, position, counters and fault code; reset reloads the start position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_position   <= c_init_pos;
      r_spin_cnt   <= '0;
      r_step_cnt   <= '0;
      r_ovr_cnt    <= '0;
      r_fault_code <= c_code_none;
    end else begin
      r_state      <= w_state;
      r_position   <= w_position;
      r_spin_cnt   <= w_spin_cnt;
      r_step_cnt   <= w_step_cnt;
      r_ovr_cnt    <= w_ovr_cnt;
      r_fault_code <= w_fault_code;
    end
  end

  // Next-state logic: simultaneous drive always wins, then per-state motion rules.
  always_comb begin
    w_state      = r_state;
    w_position   = r_position;
    w_spin_cnt   = r_spin_cnt;
    w_step_cnt   = r_step_cnt;
    w_ovr_cnt    = r_ovr_cnt;
    w_fault_code = r_fault_code;

    if (r_state != ST_FAULT && w_both) begin
      w_state      = ST_FAULT;
      w_fault_code = c_code_both;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (motor_up) begin
            w_state    = ST_SPIN_UP;
            w_spin_cnt = '0;
          end else if (motor_dn) begin
            w_state    = ST_SPIN_DN;
            w_spin_cnt = '0;
          end
        end

        ST_SPIN_UP: begin
          // Opposite drive during spin-up is harmless: nothing has moved yet.
          if (!motor_up) begin
            w_state    = ST_IDLE;
            w_spin_cnt = '0;
          end else if (r_spin_cnt == c_spin_last) begin
            w_state    = ST_MOVE_UP;
            w_step_cnt = '0;
            w_ovr_cnt  = '0;
          end else begin
            w_spin_cnt = r_spin_cnt + 1'b1;
          end
        end

        ST_SPIN_DN: begin
          if (!motor_dn) begin
            w_state    = ST_IDLE;
            w_spin_cnt = '0;
          end else if (r_spin_cnt == c_spin_last) begin
            w_state    = ST_MOVE_DN;
            w_step_cnt = '0;
            w_ovr_cnt  = '0;
          end else begin
            w_spin_cnt = r_spin_cnt + 1'b1;
          end
        end

        ST_MOVE_UP: begin
          if (motor_up) begin
            if (r_step_cnt == c_step_last) begin
              w_step_cnt = '0;
              if (r_position < c_travel) begin
                w_position = r_position + 1'b1;
              end
            end else begin
              w_step_cnt = r_step_cnt + 1'b1;
            end
            // Overrun only accumulates while pushing against the stop.
            if (r_position == c_travel) begin
              if (r_ovr_cnt == c_ovr_last) begin
                w_state      = ST_FAULT;
                w_fault_code = c_code_overrun;
              end else begin
                w_ovr_cnt = r_ovr_cnt + 1'b1;
              end
            end else begin
              w_ovr_cnt = '0;
            end
          end else if (motor_dn) begin
            w_state      = ST_FAULT;
            w_fault_code = c_code_reverse;
          end else begin
            w_state    = ST_IDLE;
            w_step_cnt = '0;
            w_ovr_cnt  = '0;
          end
        end

        ST_MOVE_DN: begin
          if (motor_dn) begin
            if (r_step_cnt == c_step_last) begin
              w_step_cnt = '0;
              if (r_position != c_pos_zero) begin
                w_position = r_position - 1'b1;
              end
            end else begin
              w_step_cnt = r_step_cnt + 1'b1;
            end
            if (r_position == c_pos_zero) begin
              if (r_ovr_cnt == c_ovr_last) begin
                w_state      = ST_FAULT;
                w_fault_code = c_code_overrun;
              end else begin
                w_ovr_cnt = r_ovr_cnt + 1'b1;
              end
            end else begin
              w_ovr_cnt = '0;
            end
          end else if (motor_up) begin
            w_state      = ST_FAULT;
            w_fault_code = c_code_reverse;
          end else begin
            w_state    = ST_IDLE;
            w_step_cnt = '0;
            w_ovr_cnt  = '0;
          end
        end

        ST_FAULT: begin
          // Exit only once the controller has let go of both drives.
          if (fault_clr && !motor_up && !motor_dn) begin
            w_state      = ST_IDLE;
            w_fault_code = c_code_none;
            w_spin_cnt   = '0;
            w_step_cnt   = '0;
            w_ovr_cnt    = '0;
          end
        end

        default: begin
          w_state = ST_IDLE;
        end
      endcase
    end
  end

  assign position   = r_position;
  assign up_limit   = (r_position == c_travel);
  assign dn_limit   = (r_position == c_pos_zero);
  assign moving     = (r_state == ST_MOVE_UP) || (r_state == ST_MOVE_DN);
  assign fault      = (r_state == ST_FAULT);
  assign fault_code = r_fault_code;

endmodule
`default_nettype wire

// File: tb/tb_motor_plant.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_plant
// Brief    : Self-checking bench for motor_plant. Directed scenarios followed
//            by randomized drive bursts, compared every cycle against a
//            run-length based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_plant;

  localparam int POS_W       = 8;
  localparam int TRAVEL      = 16;
  localparam int INIT_POS    = 0;
  localparam int START_DLY   = 2;
  localparam int STEP_DIV    = 4;
  localparam int OVERRUN_MAX = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             motor_up;
  logic             motor_dn;
  logic             fault_clr;
  logic [POS_W-1:0] position;
  logic             up_limit;
  logic             dn_limit;
  logic             moving;
  logic             fault;
  logic [1:0]       fault_code;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: a drive run is described by its direction and length.
  int m_pos;
  int m_fault;
  int m_code;
  int m_dir;    // +1 up, -1 down, 0 none
  int m_held;   // edges the current drive direction has been sampled
  int m_stop;   // edges spent pushing against an end stop

  motor_plant #(
    .POS_W       (POS_W),
    .TRAVEL      (TRAVEL),
    .INIT_POS    (INIT_POS),
    .START_DLY   (START_DLY),
    .STEP_DIV    (STEP_DIV),
    .OVERRUN_MAX (OVERRUN_MAX)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .motor_up   (motor_up),
    .motor_dn   (motor_dn),
    .fault_clr  (fault_clr),
    .position   (position),
    .up_limit   (up_limit),
    .dn_limit   (dn_limit),
    .moving     (moving),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos   = INIT_POS;
    m_fault = 0;
    m_code  = 0;
    m_dir   = 0;
    m_held  = 0;
    m_stop  = 0;
  endtask

  task automatic model_edge(input bit up, input bit dn, input bit clr);
    int  d;
    int  lim;
    bit  was_moving;
    if (m_fault != 0) begin
      if (clr && !up && !dn) begin
        m_fault = 0; m_code = 0; m_dir = 0; m_held = 0; m_stop = 0;
      end
      return;
    end
    if (up && dn) begin
      m_fault = 1; m_code = 1;
      return;
    end
    d = up ? 1 : (dn ? -1 : 0);
    was_moving = (m_dir != 0) && (m_held > START_DLY);
    if (d == 0) begin
      m_dir = 0; m_held = 0; m_stop = 0;
    end else if (m_dir == 0) begin
      m_dir = d; m_held = 1; m_stop = 0;
    end else if (d != m_dir) begin
      if (was_moving) begin
        m_fault = 1; m_code = 3;
      end else begin
        m_dir = 0; m_held = 0;
      end
    end else begin
      m_held++;
      if (was_moving) begin
        lim = (d > 0) ? TRAVEL : 0;
        if (m_pos == lim) begin
          m_stop++;
          if (m_stop == OVERRUN_MAX) begin
            m_fault = 1; m_code = 2;
          end
        end else begin
          m_stop = 0;
          if (((m_held - 1 - START_DLY) % STEP_DIV) == 0) m_pos += d;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    int exp_moving;
    exp_moving = (m_fault == 0 && m_dir != 0 && m_held > START_DLY) ? 1 : 0;
    check({tag, ".position"},   position,   m_pos);
    check({tag, ".up_limit"},   up_limit,   (m_pos == TRAVEL) ? 1 : 0);
    check({tag, ".dn_limit"},   dn_limit,   (m_pos == 0) ? 1 : 0);
    check({tag, ".moving"},     moving,     exp_moving);
    check({tag, ".fault"},      fault,      m_fault);
    check({tag, ".fault_code"}, fault_code, m_code);
  endtask

  task automatic step(input bit up, input bit dn, input bit clr, input string tag);
    motor_up  = up;
    motor_dn  = dn;
    fault_clr = clr;
    @(posedge clk);
    model_edge(up, dn, clr);
    #1;
    check_all(tag);
  endtask

  // Controller-like travel: drive until the limit is seen, then release.
  task automatic travel(input bit go_up, input string tag);
    bit done;
    done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      if (go_up ? up_limit : dn_limit) done = 1;
      else step(go_up, !go_up, 1'b0, tag);
    end
    if (!done) check({tag, ".timeout"}, 0, 1);
    step(1'b0, 1'b0, 1'b0, tag);
    check({tag, ".no_fault"}, fault, 0);
  endtask

  initial begin
    bit done;
    int kind;
    int len;
    bit up, dn;

    rst_n     = 1'b0;
    motor_up  = 1'b0;
    motor_dn  = 1'b0;
    fault_clr = 1'b0;
    model_reset();
    @(negedge clk);
    check("reset.position", position, 0);
    check("reset.dn_limit", dn_limit, 1);
    check("reset.up_limit", up_limit, 0);
    check("reset.moving",   moving,   0);
    check("reset.fault_code", fault_code, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full upward travel from edge 0.
    for (int i = 0; i <= 66; i++) begin
      step(1'b1, 1'b0, 1'b0, "up_travel");
      if (i == 5) check("pos_before_edge6", position, 0);
      if (i == 6) check("pos_at_edge6", position, 1);
      if (i == 65) check("pos_at_edge65", position, 15);
    end
    check("pos_at_edge66", position, 16);
    check("up_limit_at_top", up_limit, 1);

    // Keep pushing into the upper stop until overrun.
    for (int i = 1; i <= OVERRUN_MAX; i++) begin
      step(1'b1, 1'b0, 1'b0, "overrun");
      if (i == OVERRUN_MAX - 1) check("overrun.not_yet", fault, 0);
    end
    check("overrun.fault", fault, 1);
    check("overrun.code", fault_code, 2);
    step(1'b1, 1'b0, 1'b1, "clr_ignored");
    check("clr_ignored.fault", fault, 1);
    step(1'b0, 1'b0, 1'b0, "drop_drive");
    step(1'b0, 1'b0, 1'b1, "clr_taken");
    check("clr_taken.fault", fault, 0);
    check("clr_taken.position", position, 16);

    // Both drives in IDLE.
    step(1'b1, 1'b1, 1'b0, "both");
    check("both.code", fault_code, 1);
    check("both.position", position, 16);
    step(1'b0, 1'b0, 1'b1, "both_clr");

    // Closed loop: down, up, down.
    travel(1'b0, "loop_dn1");
    check("loop_dn1.dn_limit", dn_limit, 1);
    travel(1'b1, "loop_up");
    check("loop_up.up_limit", up_limit, 1);
    travel(1'b0, "loop_dn2");

    // Travel up again, then reset asynchronously at position 9.
    done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      if (position == 9) done = 1;
      else step(1'b1, 1'b0, 1'b0, "to_nine");
    end
    if (!done) check("to_nine.timeout", 0, 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst.position", position, INIT_POS);
    check("async_rst.dn_limit", dn_limit, 1);
    check("async_rst.moving", moving, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reverse while moving up at position 5.
    done = 0;
    for (int n = 0; n < 200 && !done; n++) begin
      if (position == 5) done = 1;
      else step(1'b1, 1'b0, 1'b0, "to_five");
    end
    if (!done) check("to_five.timeout", 0, 1);
    step(1'b0, 1'b1, 1'b0, "reverse");
    check("reverse.code", fault_code, 3);
    check("reverse.position", position, 5);
    step(1'b0, 1'b0, 1'b1, "reverse_clr");

    // One-cycle pulse: spin-up then back to idle without motion.
    step(1'b1, 1'b0, 1'b0, "pulse");
    step(1'b0, 1'b0, 1'b0, "pulse_off");
    step(1'b0, 1'b0, 1'b0, "pulse_idle");
    check("pulse.position", position, 5);
    check("pulse.moving", moving, 0);

    // Randomized drive bursts.
    for (int b = 0; b < 80; b++) begin
      kind = $urandom_range(0, 11);
      len  = (kind < 4) ? $urandom_range(1, 4) : $urandom_range(1, 90);
      up   = (kind == 0) || (kind >= 2 && kind <= 6);
      dn   = (kind == 0) || (kind >= 7 && kind <= 10);
      for (int c = 0; c < len; c++) begin
        step(up, dn, ($urandom_range(0, 3) == 0), "random");
      end
      if (m_fault != 0 && $urandom_range(0, 1) == 1) begin
        step(1'b0, 1'b0, 1'b0, "random_rel");
        step(1'b0, 1'b0, 1'b1, "random_clr");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/motor_plant.md
# motor_plant

Synthesizable behavioural model of the door/motor actuator driven by the motor controller. It consumes `motor_up`/`motor_dn` and produces the `up_limit`/`dn_limit` switch inputs the controller needs, closing the loop for simulation and FPGA self-test. It models spin-up delay, finite travel speed and end-stop overrun, and flags illegal drive patterns as sticky faults.

## Interface
- `POS_W`, 8, width of the position register.
- `TRAVEL`, 16, position of the upper end stop. Legal range 1..2^POS_W-1.
- `INIT_POS`, 0, position loaded at reset. Legal range 0..TRAVEL.
- `START_DLY`, 2, cycles of held drive before motion starts. Minimum 1.
- `STEP_DIV`, 4, cycles per position step while moving. Minimum 1.
- `OVERRUN_MAX`, 8, cycles of drive into an end stop before an overrun fault. Minimum 1.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `motor_up` input 1: drive toward TRAVEL.
- `motor_dn` input 1: drive toward 0.
- `fault_clr` input 1: request fault exit.
- `position` output POS_W: current position, registered.
- `up_limit` output 1: equals (position == TRAVEL), decoded from the registered position with no extra latency.
- `dn_limit` output 1: equals (position == 0), decoded from the registered position.
- `moving` output 1: high in MOVE_UP or MOVE_DN.
- `fault` output 1: high in FAULT.
- `fault_code` output 2: 0 none, 1 BOTH, 2 OVERRUN, 3 REVERSE.

## Operation
- States: IDLE, SPIN_UP, SPIN_DN, MOVE_UP, MOVE_DN, FAULT. Internal counters: spin counter, step counter (0..STEP_DIV-1), overrun counter.
- **Reset values:**
  - State IDLE, position=INIT_POS, all counters 0.
  - moving=0, fault=0, fault_code=0.
  - up_limit and dn_limit follow INIT_POS (defaults: dn_limit=1, up_limit=0).
- **Priority in every non-FAULT state:** motor_up & motor_dn is checked first and goes to FAULT with code 1.
- **IDLE:**
  - motor_up → SPIN_UP, spin counter=0.
  - motor_dn → SPIN_DN, spin counter=0.
  - Otherwise stay. Position is held.
- **SPIN_UP:**
  - Drive dropped → IDLE.
  - motor_dn alone → IDLE. There is no motion yet, so this is not a fault.
  - Drive held with spin counter == START_DLY-1 → MOVE_UP, step counter=0.
  - Drive held otherwise → spin counter +1.
  - SPIN_DN is symmetric.
- **MOVE_UP:**
  - Neither drive asserted → IDLE. Step and overrun counters clear; position is held.
  - motor_dn alone → FAULT with code 3.
  - motor_up held: step counter advances every cycle and wraps at STEP_DIV-1. On the wrap cycle, position +1 if position < TRAVEL.
  - motor_up held at position == TRAVEL: overrun counter +1. When it reaches OVERRUN_MAX → FAULT with code 2.
  - motor_up held below TRAVEL: overrun counter is held at 0.
- **MOVE_DN** mirrors MOVE_UP:
  - Decrement toward 0; no decrement below 0.
  - Overrun counts at position == 0.
  - motor_up alone → code 3.
- **FAULT:**
  - position and fault_code are frozen.
  - fault_clr=1 with motor_up=motor_dn=0 → IDLE, fault_code=0, counters cleared.
  - fault_clr while any drive is asserted is ignored.
- **Arithmetic:** position never wraps and always stays within 0..TRAVEL. All counters saturate or clear; none of them wraps into a false event.
- **Reset mid-motion:** position reloads INIT_POS immediately (asynchronous); any in-progress fault is lost.

## Timing
- Drive first sampled high at edge k in IDLE:
  - SPIN occupies edges k+1..k+START_DLY-1.
  - MOVE is entered at edge k+START_DLY.
  - First position change at edge k+START_DLY+STEP_DIV (defaults: k+6).
- Each subsequent step follows STEP_DIV edges later.
- Full travel 0→TRAVEL with defaults: position reaches 16 at edge k+2+64=k+66. up_limit is high in the cycle after that edge.
- Overrun: fault asserts at the OVERRUN_MAX-th edge with drive held at the stop (defaults: 8 cycles).
- A controller that releases drive one cycle after the limit asserts never faults.
- Fault entry and exit are one edge each; fault and fault_code change on the same edge.

## Test plan
- Reset with defaults → position=0, dn_limit=1, up_limit=0, moving=0, fault_code=0.
- Hold motor_up from edge 0 → position=1 at edge 6, position=16 at edge 66, up_limit=1. Release drive at edge 67 → IDLE, no fault.
- Keep motor_up held after position=16 → fault=1, fault_code=2 on the 8th cycle at the stop. fault_clr with drive still high is ignored. Drop drive, then fault_clr → fault=0, position stays 16.
- Assert motor_up and motor_dn together in IDLE → fault_code=1 on the next edge, position unchanged.
- In MOVE_UP at position 5, switch to motor_dn alone → fault_code=3, position frozen at 5. Pulse motor_up for only 1 cycle in IDLE → SPIN_UP, then IDLE, with no motion.
- Close the loop with the motor controller (activate pulses) → alternating full up/down travels, with the limits toggling at 16 and 0 and fault never set. Assert rst_n low mid-travel at position 9 → position=0 immediately.
